aopac_dt_model: RTL and testbench
=================================

Name: aopac_dt_model

Overview:
- Discrete-time, fixed-point behavioural macromodel of an N-channel op-amp bank, clocked on the system clock.
- Successor to the single-channel real-valued amplifier model; same place in the design: behavioural stand-in for analog amplifiers in mixed-signal simulation and FPGA emulation.
- Adds channel count, integer gain, a single-pole IIR response, slew limiting, rail clamping, a per-channel enable/settle state machine and status flags.
- Channels are updated round-robin, one per clock.

Parameters:
- NCH, 2, number of amplifier channels (1..16).
- W, 16, signed sample width; 1 LSB = 1 mV.
- GAIN, 100, open-loop integer gain applied to (inp - inn).
- POLE_SHIFT, 7, pole coefficient alpha = 2^-POLE_SHIFT; 0 means no filtering.
- SLEW_MAX, 50, maximum |output change| per channel update, in LSB.
- SETTLE, 8, channel updates after enable before valid asserts (1..255).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en  in  NCH  per-channel enable
- inp  in  NCH*W  non-inverting inputs, signed, channel k at [k*W +: W]
- inn  in  NCH*W  inverting inputs, signed, same packing
- vdda  in  W  upper rail, signed
- vssa  in  W  lower rail, signed
- out  out  NCH*W  registered channel outputs, signed
- sat  out  NCH  target clamped to a rail at the last update
- valid  out  NCH  channel in ACTIVE state
- rail_err  out  1  registered; high while vssa > vdda
- upd_ch  out  clog2(NCH) (min 1)  index of the channel updated this cycle

Behaviour:
- Reset: all outputs are 0, upd_ch is 0, and every channel is in state OFF. Reset takes priority over every other event.
- Scheduler:
  - upd_ch increments every cycle and wraps from NCH-1 to 0.
  - Channel k updates only in cycles where upd_ch == k; the result is visible on out the following cycle.
  - Update period is NCH cycles.
- Update arithmetic, evaluated at full precision with no intermediate overflow:
  - diff = inp - inn, W+1 bits.
  - tgt = GAIN*diff, clamped to [vssa, vdda]; sat = 1 if the clamp was applied.
  - err = tgt - out; d = err >>> POLE_SHIFT (arithmetic shift, floor).
  - If d == 0 and err > 0, then d = 1. This guarantees convergence.
  - d is clamped to [-SLEW_MAX, +SLEW_MAX].
  - out_next = out + d, clamped to [vssa, vdda].
- Per-channel state machine (transitions evaluated only in that channel's update slot):
  - OFF: out = 0, sat = 0, valid = 0, settle count = 0. Goes to SETTLE if en[k] = 1.
  - SETTLE: perform the update and increment the count. Goes to ACTIVE when the count reaches SETTLE (valid rises in the same cycle out is written). Goes to OFF if en[k] = 0.
  - ACTIVE: perform the update; valid = 1. Goes to OFF if en[k] = 0.
  - The transition to OFF clears out to 0 in that slot; no decay.
- Boundaries:
  - Changes to en between a channel's slots are ignored until its slot.
  - If en toggles 1→0→1 within one period, it is seen as 1 and no reset occurs.
  - rail_err = 1: no channel updates. out, sat and valid hold; state and count are frozen; the scheduler keeps running. When the fault clears, updates resume.
  - vssa == vdda is legal; out is forced to that value.
  - Rails changing mid-operation take effect at the next update of each channel. out may be outside new rails until its slot.
  - Reset asserted mid-operation returns every channel to OFF at the next clock.

Test Plan:
- Reset defaults: reset high 3 cycles, then low; en = 0 → out = 0, sat = 0, valid = 0, rail_err = 0, upd_ch toggles 0,1,0,1.
- First-order step (NCH = 2, defaults, vdda = 3300, vssa = 0): en[0] = 1, inp0 = 1000, inn0 = 990 → tgt = 1000; first ch0 update gives out0 = 7, second gives 14. valid[0] rises on the 8th ch0 update (cycle 15 after en is sampled). Channel 1 stays 0.
- Saturation and slew (POLE_SHIFT = 0): inp0 = 1100, inn0 = 1000 → sat[0] = 1. out0 steps 50, 100, 150, 200 over 4 ch0 updates and finally holds at 3300. Negative direction with inp0 < inn0 → clamps at 0.
- Convergence floor (POLE_SHIFT = 7): out0 settled at 1000, tgt moved to 1005 → out0 increments by 1 per update to exactly 1005 and then holds.
- Disable and rail fault: en[0] = 0 mid-SETTLE → at the ch0 slot out0 = 0, valid0 = 0; re-enable restarts the count from 0. Setting vssa = 100, vdda = 50 → rail_err = 1 next cycle and all outputs freeze; restoring the rails resumes updates.
- Reset mid-operation: both channels ACTIVE at out = 1000 when reset is pulsed for 1 cycle → next cycle all outputs = 0 and upd_ch = 0; with en held at 1, valid returns after SETTLE updates.

Source files
------------

// File: rtl/aopac_dt_model.sv
// aopac_dt_model: fixed-point op-amp bank macromodel, one channel per clock.
// Single-pole IIR toward a clamped gain target, slew and rail limited.
module aopac_dt_model #(
    parameter int NCH        = 2,
    parameter int W          = 16,
    parameter int GAIN       = 100,
    parameter int POLE_SHIFT = 7,
    parameter int SLEW_MAX   = 50,
    parameter int SETTLE     = 8,
    localparam int UW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   en,
    input  logic [NCH*W-1:0] inp,
    input  logic [NCH*W-1:0] inn,
    input  logic [W-1:0]     vdda,
    input  logic [W-1:0]     vssa,
    output logic [NCH*W-1:0] out,
    output logic [NCH-1:0]   sat,
    output logic [NCH-1:0]   valid,
    output logic             rail_err,
    output logic [UW-1:0]    upd_ch
);

    // Wide enough that GAIN*diff and all later sums never overflow.
    localparam int XW = W + 34;

    localparam logic [1:0] ST_OFF    = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    localparam logic signed [XW-1:0] ZERO  = '0;
    localparam logic signed [XW-1:0] ONE   = XW'(1);
    localparam logic signed [XW-1:0] SMAX  = XW'(SLEW_MAX);
    localparam logic signed [XW-1:0] SMIN  = -SMAX;
    localparam logic signed [XW-1:0] KGAIN = XW'(GAIN);

    logic [1:0] st [NCH];
    logic [7:0] cnt [NCH];

    logic [W-1:0] sel_p;
    logic [W-1:0] sel_n;
    logic [W-1:0] sel_o;
    logic [1:0]   sel_st;
    logic [7:0]   sel_cnt;
    logic [7:0]   cnt_n;

    logic signed [XW-1:0] lo;
    logic signed [XW-1:0] hi;
    logic signed [XW-1:0] tgt_raw;
    logic signed [XW-1:0] tgt;
    logic signed [XW-1:0] err;
    logic signed [XW-1:0] d;
    logic signed [XW-1:0] cand;
    logic [W-1:0]         nxt;
    logic                 clip;
    logic                 fault;

    always_comb begin
        sel_p   = '0;
        sel_n   = '0;
        sel_o   = '0;
        sel_st  = ST_OFF;
        sel_cnt = '0;
        for (int k = 0; k < NCH; k++) begin
            if (upd_ch == UW'(k)) begin
                sel_p   = inp[k*W +: W];
                sel_n   = inn[k*W +: W];
                sel_o   = out[k*W +: W];
                sel_st  = st[k];
                sel_cnt = cnt[k];
            end
        end
    end

    always_comb begin
        fault   = $signed(vssa) > $signed(vdda);
        lo      = XW'($signed(vssa));
        hi      = XW'($signed(vdda));
        tgt_raw = (XW'($signed(sel_p)) - XW'($signed(sel_n))) * KGAIN;
        clip    = (tgt_raw > hi) || (tgt_raw < lo);
        tgt     = (tgt_raw > hi) ? hi : (tgt_raw < lo) ? lo : tgt_raw;
        err     = tgt - XW'($signed(sel_o));
        d       = err >>> POLE_SHIFT;
        // Floor shift stalls short of a positive target; force a 1-LSB step.
        if (d == ZERO && err > ZERO) begin
            d = ONE;
        end
        if (d > SMAX) begin
            d = SMAX;
        end else if (d < SMIN) begin
            d = SMIN;
        end
        cand  = XW'($signed(sel_o)) + d;
        nxt   = (cand > hi) ? W'(hi) : (cand < lo) ? W'(lo) : W'(cand);
        cnt_n = sel_cnt + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            upd_ch   <= '0;
            rail_err <= 1'b0;
            out      <= '0;
            sat      <= '0;
            valid    <= '0;
            for (int k = 0; k < NCH; k++) begin
                st[k]  <= ST_OFF;
                cnt[k] <= '0;
            end
        end else begin
            upd_ch   <= (upd_ch == UW'(NCH - 1)) ? '0 : upd_ch + UW'(1);
            rail_err <= fault;
            for (int k = 0; k < NCH; k++) begin
                if (!fault && upd_ch == UW'(k)) begin
                    if (!en[k]) begin
                        out[k*W +: W] <= '0;
                        sat[k]        <= 1'b0;
                        valid[k]      <= 1'b0;
                        st[k]         <= ST_OFF;
                        cnt[k]        <= '0;
                    end else begin
                        out[k*W +: W] <= nxt;
                        sat[k]        <= clip;
                        if (sel_st == ST_ACTIVE) begin
                            valid[k] <= 1'b1;
                        end else begin
                            cnt[k] <= cnt_n;
                            if (cnt_n >= 8'(SETTLE)) begin
                                st[k]    <= ST_ACTIVE;
                                valid[k] <= 1'b1;
                            end else begin
                                st[k] <= ST_SETTLE;
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_aopac_dt_model.sv
// tb_aopac_dt_model: directed vectors, timestamped scoreboard and monitor.
// Instance a uses default poles, instance b has no filtering (POLE_SHIFT 0).
module tb_aopac_dt_model;

    localparam int NCH = 2;
    localparam int W   = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NCH-1:0]   en = '0;
    logic [NCH*W-1:0] inp = '0;
    logic [NCH*W-1:0] inn = '0;
    logic [W-1:0]     vdda = 16'd3300;
    logic [W-1:0]     vssa = 16'd0;

    logic [NCH*W-1:0] out_a, out_b;
    logic [NCH-1:0]   sat_a, sat_b, valid_a, valid_b;
    logic             rail_a, rail_b;
    logic             upd_a, upd_b;

    always #5 clk = ~clk;

    aopac_dt_model u_a (
        .clk(clk), .reset(reset), .en(en), .inp(inp), .inn(inn),
        .vdda(vdda), .vssa(vssa), .out(out_a), .sat(sat_a),
        .valid(valid_a), .rail_err(rail_a), .upd_ch(upd_a)
    );

    aopac_dt_model #(.POLE_SHIFT(0)) u_b (
        .clk(clk), .reset(reset), .en(en), .inp(inp), .inn(inn),
        .vdda(vdda), .vssa(vssa), .out(out_b), .sat(sat_b),
        .valid(valid_b), .rail_err(rail_b), .upd_ch(upd_b)
    );

    typedef struct {
        int    t;
        int    dut;
        int    ch;
        int    o;
        bit    s;
        bit    v;
        bit    re;
        string nm;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int tick = 0;
    int slot = 0;
    int b, r;

    always @(posedge clk) begin
        tick <= tick + 1;
        slot <= reset ? 0 : ((slot == NCH - 1) ? 0 : slot + 1);
    end

    task automatic ex(input int t, input int dut, input int ch, input int o,
                      input bit s, input bit v, input bit re, input string nm);
        exp_t e;
        e.t = t; e.dut = dut; e.ch = ch; e.o = o;
        e.s = s; e.v = v; e.re = re; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic check(input exp_t e);
        logic signed [W-1:0] ao;
        bit as, av, are;
        if (e.dut == 0) begin
            ao = out_a[e.ch*W +: W]; as = sat_a[e.ch];
            av = valid_a[e.ch]; are = rail_a;
        end else begin
            ao = out_b[e.ch*W +: W]; as = sat_b[e.ch];
            av = valid_b[e.ch]; are = rail_b;
        end
        total++;
        if (e.t != tick || int'(ao) != e.o || as != e.s ||
            av != e.v || are != e.re) begin
            bad++;
            $display("FAIL %s dut%0d ch%0d t=%0d/%0d: got out=%0d sat=%0b valid=%0b rail_err=%0b want out=%0d sat=%0b valid=%0b rail_err=%0b",
                     e.nm, e.dut, e.ch, tick, e.t, ao, as, av, are,
                     e.o, e.s, e.v, e.re);
        end
    endtask

    always @(negedge clk) begin
        total++;
        if (int'(upd_a) != slot || int'(upd_b) != slot) begin
            bad++;
            $display("FAIL upd_ch t=%0d: got %0d/%0d want %0d",
                     tick, upd_a, upd_b, slot);
        end
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].t <= tick) begin
                check(q[i]);
                q.delete(i);
            end
        end
    end

    task automatic sync0();
        int n;
        n = 0;
        @(negedge clk);
        while (slot != 0 && n < 4) begin
            @(negedge clk);
            n++;
        end
        if (slot != 0) begin
            total++;
            bad++;
            $display("FAIL sync0: slot %0d want 0", slot);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d pending want 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        // Reset defaults
        repeat (3) @(negedge clk);
        reset = 1'b0;
        b = tick;
        for (int d = 1; d <= 4; d++) begin
            for (int c = 0; c < NCH; c++) begin
                ex(b + d, 0, c, 0, 0, 0, 0, "rst_a");
                ex(b + d, 1, c, 0, 0, 0, 0, "rst_b");
            end
        end
        drain();

        // First-order step toward 1000
        sync0(); b = tick;
        en = 2'b01; inp[15:0] = 16'd1000; inn[15:0] = 16'd990;
        ex(b + 1, 0, 0, 7, 0, 0, 0, "step1");
        ex(b + 3, 0, 0, 14, 0, 0, 0, "step2");
        ex(b + 13, 0, 0, 49, 0, 0, 0, "step7");
        ex(b + 15, 0, 0, 56, 0, 1, 0, "step8_valid");
        ex(b + 2, 0, 1, 0, 0, 0, 0, "ch1_idle");
        ex(b + 16, 0, 1, 0, 0, 0, 0, "ch1_idle2");
        ex(b + 1, 1, 0, 50, 0, 0, 0, "step_fast");
        drain();

        // Convergence floor: settle at 1000, then target 1005 via the rail
        repeat (2000) @(negedge clk);
        sync0(); b = tick;
        ex(b + 1, 0, 0, 1000, 0, 1, 0, "conv_a");
        ex(b + 1, 1, 0, 1000, 0, 1, 0, "conv_b");
        repeat (2) @(negedge clk); b = tick;
        vdda = 16'd1005; inp[15:0] = 16'd1001;
        ex(b + 1, 0, 0, 1001, 1, 1, 0, "floor1");
        ex(b + 3, 0, 0, 1002, 1, 1, 0, "floor2");
        ex(b + 5, 0, 0, 1003, 1, 1, 0, "floor3");
        ex(b + 7, 0, 0, 1004, 1, 1, 0, "floor4");
        ex(b + 9, 0, 0, 1005, 1, 1, 0, "floor5");
        ex(b + 11, 0, 0, 1005, 1, 1, 0, "floor_hold");
        ex(b + 1, 1, 0, 1005, 1, 1, 0, "floor_fast");
        drain();

        // Saturation and slew, with an en glitch between slots
        sync0(); b = tick;
        en = 2'b00; vdda = 16'd3300;
        inp[15:0] = 16'd1100; inn[15:0] = 16'd1000;
        ex(b + 1, 0, 0, 0, 0, 0, 0, "off_a");
        ex(b + 1, 1, 0, 0, 0, 0, 0, "off_b");
        repeat (2) @(negedge clk); b = tick;
        en = 2'b01;
        ex(b + 1, 1, 0, 50, 1, 0, 0, "slew1");
        ex(b + 3, 1, 0, 100, 1, 0, 0, "slew2");
        ex(b + 5, 1, 0, 150, 1, 0, 0, "slew3");
        ex(b + 7, 1, 0, 200, 1, 0, 0, "slew4");
        ex(b + 15, 1, 0, 400, 1, 1, 0, "slew8_valid");
        ex(b + 1, 0, 0, 25, 1, 0, 0, "pole_sat1");
        ex(b + 3, 0, 0, 50, 1, 0, 0, "pole_sat2");
        @(negedge clk); en = 2'b00;
        @(negedge clk); en = 2'b01;
        drain();
        repeat (160) @(negedge clk);
        sync0(); b = tick;
        ex(b + 1, 1, 0, 3300, 1, 1, 0, "rail_hi");
        repeat (2) @(negedge clk); b = tick;
        inp[15:0] = 16'd900;
        ex(b + 1, 1, 0, 3250, 1, 1, 0, "neg1");
        ex(b + 3, 1, 0, 3200, 1, 1, 0, "neg2");
        drain();
        repeat (160) @(negedge clk);
        sync0(); b = tick;
        ex(b + 1, 1, 0, 0, 1, 1, 0, "rail_lo");
        drain();

        // Disable mid-settle restarts the count
        sync0(); b = tick;
        en = 2'b00; inp[15:0] = 16'd1000; inn[15:0] = 16'd990;
        ex(b + 1, 0, 0, 0, 0, 0, 0, "dis_a");
        ex(b + 1, 1, 0, 0, 0, 0, 0, "dis_b");
        repeat (2) @(negedge clk);
        en = 2'b01;
        ex(b + 3, 0, 0, 7, 0, 0, 0, "settle1");
        ex(b + 7, 0, 0, 21, 0, 0, 0, "settle3");
        repeat (6) @(negedge clk);
        en = 2'b00;
        ex(b + 9, 0, 0, 0, 0, 0, 0, "mid_off_a");
        ex(b + 9, 1, 0, 0, 0, 0, 0, "mid_off_b");
        repeat (2) @(negedge clk);
        en = 2'b01;
        ex(b + 23, 0, 0, 49, 0, 0, 0, "restart7");
        ex(b + 25, 0, 0, 56, 0, 1, 0, "restart8");
        ex(b + 25, 1, 0, 400, 0, 1, 0, "restart8_b");
        repeat (16) @(negedge clk); b = tick;

        // Rail fault freezes everything until the rails recover
        vssa = 16'd100; vdda = 16'd50;
        ex(b + 1, 0, 0, 56, 0, 1, 1, "frz1");
        ex(b + 3, 0, 0, 56, 0, 1, 1, "frz2");
        ex(b + 5, 0, 0, 56, 0, 1, 1, "frz3");
        ex(b + 1, 1, 0, 400, 0, 1, 1, "frz_b");
        ex(b + 2, 0, 1, 0, 0, 0, 1, "frz_ch1");
        repeat (5) @(negedge clk);
        vssa = 16'd0; vdda = 16'd3300;
        ex(b + 7, 0, 0, 63, 0, 1, 0, "resume_a");
        ex(b + 7, 1, 0, 450, 0, 1, 0, "resume_b");
        drain();

        // Collapsed rails force the output
        sync0(); b = tick;
        vssa = 16'd500; vdda = 16'd500;
        ex(b + 1, 0, 0, 500, 1, 1, 0, "eq_a");
        ex(b + 1, 1, 0, 500, 1, 1, 0, "eq_b");
        repeat (2) @(negedge clk);
        vssa = 16'd0; vdda = 16'd3300;
        drain();

        // Reset pulse with both channels active
        en = 2'b11; inp[31:16] = 16'd1000; inn[31:16] = 16'd990;
        repeat (2000) @(negedge clk);
        sync0(); b = tick;
        ex(b + 1, 0, 0, 1000, 0, 1, 0, "act_a0");
        ex(b + 2, 0, 1, 1000, 0, 1, 0, "act_a1");
        ex(b + 1, 1, 0, 1000, 0, 1, 0, "act_b0");
        ex(b + 2, 1, 1, 1000, 0, 1, 0, "act_b1");
        repeat (3) @(negedge clk); r = tick;
        reset = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            ex(r + 1, 0, c, 0, 0, 0, 0, "rst_mid_a");
            ex(r + 1, 1, c, 0, 0, 0, 0, "rst_mid_b");
        end
        @(negedge clk);
        reset = 1'b0;
        ex(r + 2, 0, 0, 7, 0, 0, 0, "post_rst0");
        ex(r + 3, 0, 1, 7, 0, 0, 0, "post_rst1");
        ex(r + 14, 0, 0, 49, 0, 0, 0, "post_rst_7");
        ex(r + 16, 0, 0, 56, 0, 1, 0, "post_rst_v0");
        ex(r + 17, 0, 1, 56, 0, 1, 0, "post_rst_v1");
        ex(r + 16, 1, 0, 400, 0, 1, 0, "post_rst_b0");
        ex(r + 17, 1, 1, 400, 0, 1, 0, "post_rst_b1");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
